// File: rtl/spect_cfg_pkg.sv
// spect_cfg_pkg: shared widths, requester indices and arbiter FSM state encoding
package spect_cfg_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int REQ_UART = 0;
  localparam int REQ_SEQ = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, search starts just after the last grant
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] last_i,
  output logic [N-1:0] gnt_o
);
  int   lidx;
  logic found;
  always_comb begin
    gnt_o = '0;
    lidx = 0;
    found = 1'b0;
    for (int i = 0; i < N; i++) lidx = last_i[i] ? i : lidx;
    for (int k = 1; k <= N; k++)
      for (int i = 0; i < N; i++)
        if (!found && req_i[i] && i == (lidx + k) % N) begin
          gnt_o[i] = 1'b1;
          found = 1'b1;
        end
  end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: serialises requester commands onto the single regfile port
module regfile_arbiter
  import spect_cfg_pkg::*;
#(
  parameter int NUMREGS = 9,
  parameter int NUMREQ = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUMREQ-1:0]              req,
  input  logic [NUMREQ-1:0]              req_wr,
  input  logic [NUMREQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUMREQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUMREQ-1:0]              gnt,
  output logic [NUMREQ-1:0]              done,
  output logic                           rsp_err,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           write,
  output logic [ADDR_W-1:0]              write_addr,
  output logic [DATA_W-1:0]              write_data,
  output logic                           read,
  output logic [ADDR_W-1:0]              read_addr,
  input  logic [DATA_W-1:0]              read_data,
  output logic [7:0]                     err_count
);
  localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUMREGS);
  localparam logic [NUMREQ-1:0] LAST_RST = {1'b1, {(NUMREQ - 1) {1'b0}}};
  state_e state_q, state_d;
  logic [NUMREQ-1:0] owner_q, owner_d, last_q, last_d, pick;
  logic wr_q, wr_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic sel_wr, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rr_arbiter #(.N(NUMREQ)) u_rr (
    .req_i (req),
    .last_i(last_q),
    .gnt_o (pick)
  );
  always_comb begin
    sel_wr = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUMREQ; i++)
      if (pick[i]) begin
        sel_wr = req_wr[i];
        sel_addr = req_addr[i];
        sel_wdata = req_wdata[i];
      end
  end
  assign in_range = {1'b0, addr_q} < NREG;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE:
        if (|req) begin
          state_d = ISSUE;
          owner_d = pick;
          last_d = pick;
          wr_d = sel_wr;
          addr_d = sel_addr;
          wdata_d = sel_wdata;
          err_d = 1'b0;
          rdata_d = '0;
        end
      ISSUE: begin
        state_d = !in_range || wr_q ? RESP : RDWAIT;
        err_d = !in_range;
        cnt_d = !in_range && cnt_q != 8'hFF ? cnt_q + 8'd1 : cnt_q;
      end
      RDWAIT: begin
        rdata_d = read_data;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= LAST_RST;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end
  // Strobes and pulses decode straight from state so they can never outlive their cycle
  assign gnt = state_q == ISSUE ? owner_q : '0;
  assign done = state_q == RESP ? owner_q : '0;
  assign write = state_q == ISSUE && in_range && wr_q;
  assign read = state_q == ISSUE && in_range && !wr_q;
  assign write_addr = addr_q;
  assign read_addr = addr_q;
  assign write_data = wdata_q;
  assign rsp_err = err_q;
  assign rsp_rdata = rdata_q;
  assign err_count = cnt_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: random and directed traffic scored against a transaction-level model
module tb_regfile_arbiter;
  localparam int NUMREGS = 9;
  typedef struct {bit wr; bit [7:0] addr; bit [7:0] wdata;} cmd_t;
  typedef struct {int who; int due; bit err; bit [7:0] rdata; bit [7:0] cnt;} exp_t;
  logic clk = 1'b0, reset;
  logic [1:0] req, req_wr, gnt, done;
  logic [1:0][7:0] req_addr, req_wdata;
  logic rsp_err, write, read;
  logic [7:0] rsp_rdata, write_addr, write_data, read_addr, read_data, err_count;
  logic [7:0] mem[256];
  bit [7:0] ref_mem[256];
  cmd_t q0[$], q1[$];
  exp_t sb[$];
  int gnt_log[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, busy_until = -1, last_w = 1, m_w, exp_gnt;
  bit prev_idle = 1'b1, m_inr, m_ew, m_er;
  bit [7:0] m_cnt = 0;
  bit [1:0] prev_req, prev_wr;
  bit [1:0][7:0] prev_addr, prev_wdata;
  exp_t m_e;
  regfile_arbiter #(.NUMREGS(NUMREGS), .NUMREQ(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .write(write), .write_addr(write_addr),
    .write_data(write_data), .read(read), .read_addr(read_addr),
    .read_data(read_data), .err_count(err_count)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (write) mem[write_addr] <= write_data;
    if (read) read_data <= mem[read_addr];
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Monitor: predicts each grant from the previous cycle's requests and scores every done
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sb.delete();
      last_w = 1;
      busy_until = cyc;
      m_cnt = 0;
      prev_req = 0;
      prev_idle = 1'b1;
    end else begin
      exp_gnt = 0;
      if (prev_idle && prev_req != 0) begin
        m_w = prev_req == 2'b11 ? 1 - last_w : (prev_req[1] ? 1 : 0);
        exp_gnt = 1 << m_w;
      end
      check("gnt", gnt, exp_gnt);
      if (exp_gnt != 0) begin
        m_inr = prev_addr[m_w] < NUMREGS;
        m_ew = prev_wr[m_w] && m_inr;
        m_er = !prev_wr[m_w] && m_inr;
        check("write", write, m_ew);
        check("read", read, m_er);
        if (m_ew) begin
          check("write_addr", write_addr, prev_addr[m_w]);
          check("write_data", write_data, prev_wdata[m_w]);
          ref_mem[prev_addr[m_w]] = prev_wdata[m_w];
        end
        if (m_er) check("read_addr", read_addr, prev_addr[m_w]);
        if (!m_inr && m_cnt != 8'hFF) m_cnt++;
        m_e.who = m_w;
        m_e.err = !m_inr;
        m_e.rdata = m_er ? ref_mem[prev_addr[m_w]] : 8'h00;
        m_e.cnt = m_cnt;
        m_e.due = cyc + (m_er ? 2 : 1);
        busy_until = m_e.due;
        sb.push_back(m_e);
        gnt_log.push_back(m_w);
        last_w = m_w;
      end else check("no_strobe", {write, read}, 0);
      if (done != 0 || (sb.size() != 0 && sb[0].due == cyc)) begin
        if (sb.size() == 0) check("done_unexpected", done, 0);
        else begin
          m_e = sb.pop_front();
          check("done_who", done, 1 << m_e.who);
          check("done_cycle", cyc, m_e.due);
          check("rsp_err", rsp_err, m_e.err);
          check("rsp_rdata", rsp_rdata, m_e.rdata);
          check("err_count", err_count, m_e.cnt);
        end
      end
      prev_idle = cyc > busy_until;
      prev_req = req;
      prev_wr = req_wr;
      prev_addr = req_addr;
      prev_wdata = req_wdata;
    end
  end
  task automatic drive();
    req[0] = q0.size() != 0;
    req[1] = q1.size() != 0;
    if (q0.size() != 0) {req_wr[0], req_addr[0], req_wdata[0]} = {q0[0].wr, q0[0].addr, q0[0].wdata};
    if (q1.size() != 0) {req_wr[1], req_addr[1], req_wdata[1]} = {q1[0].wr, q1[0].addr, q1[0].wdata};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (gnt[0] && q0.size() != 0) void'(q0.pop_front());
    if (gnt[1] && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask
  task automatic push(int who, bit wr, bit [7:0] a, bit [7:0] d);
    cmd_t c;
    c.wr = wr;
    c.addr = a;
    c.wdata = d;
    if (who == 0) q0.push_back(c);
    else q1.push_back(c);
  endtask
  task automatic wait_drain(int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d cycles pending, limit %0d", n, budget);
    end
    step();
    step();
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_write"}, write, 0);
    check({tag, "_read"}, read, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_write_addr"}, write_addr, 0);
    check({tag, "_write_data"}, write_data, 0);
    check({tag, "_read_addr"}, read_addr, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask
  initial begin
    reset = 1'b1;
    req = 0;
    req_wr = 0;
    req_addr = 0;
    req_wdata = 0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    push(0, 1, 3, 8'hA5);
    drive();
    wait_drain(50);
    push(1, 0, 3, 0);
    drive();
    wait_drain(50);
    gnt_log.delete();
    push(0, 1, 1, 8'h11);
    push(0, 1, 2, 8'h22);
    push(1, 1, 4, 8'h33);
    push(1, 1, 5, 8'h44);
    drive();
    wait_drain(100);
    check("order_len", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("order", gnt_log[i], i % 2);
    repeat (600) begin
      if ($urandom_range(0, 3) == 0)
        push($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), 8'($urandom));
      drive();
      step();
    end
    wait_drain(3000);
    repeat (300) push(0, 1, 9, 8'($urandom));
    drive();
    wait_drain(2000);
    check("err_sat", err_count, 8'hFF);
    push(0, 0, 3, 0);
    drive();
    for (int n = 0; n < 20 && !read; n++) step();
    check("rdwait_read_seen", read, 1);
    step();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    gnt_log.delete();
    push(0, 1, 6, 8'h5A);
    push(1, 1, 7, 8'hC3);
    drive();
    wait_drain(50);
    check("post_rst_first", gnt_log.size() != 0 ? gnt_log[0] : 99, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
